qdr_user_bram_emu: RTL and testbench

//  Responder side of the QDR user-app interface used by the dflow generator core. Accepts

---
 rtl/qdr_emu_pkg.sv | 20 ++
 rtl/qdr_emu_sdp_ram.sv | 37 +++
 rtl/qdr_user_bram_emu.sv | 176 +++++++++++++++++
 tb/tb_qdr_user_bram_emu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_emu_pkg.sv
// Shared constants and state encoding for the QDR user-app BRAM emulator.
package qdr_emu_pkg;

    localparam int QDR_DATA_WIDTH   = 36;
    localparam int QDR_BURST_LENGTH = 4;
    localparam int QDR_ADDR_WIDTH   = 19;
    localparam int W                = QDR_DATA_WIDTH * QDR_BURST_LENGTH;

    typedef enum logic [0:0] {
        CALIB = 1'b0,
        READY = 1'b1
    } emu_state_e;

    // True when any address bit at or above low_bits is set (address would alias).
    function automatic logic upper_bits_set(input logic [QDR_ADDR_WIDTH-1:0] addr,
                                            input int unsigned low_bits);
        return (addr >> low_bits) != {QDR_ADDR_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/qdr_emu_sdp_ram.sv
// Simple dual-port BRAM: one write port, one registered read port.
// A read and write to the same address in the same cycle returns the new data.
module qdr_emu_sdp_ram
    import qdr_emu_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem_r [0:(2**ADDR_BITS)-1];

    // Write port; storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port with write-first bypass on address collision.
    always_ff @(posedge clk) begin
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem_r[raddr];
            end
        end
    end

endmodule

// File: rtl/qdr_user_bram_emu.sv
// QDR user-app responder backed by on-chip BRAM, drop-in for the QDR controller.
// Optional build macro: QDR_EMU_ZERO_INIT_EN -- calibration becomes a sweep that
// writes zero to every word; init_calib_complete rises the cycle after the last write.
module qdr_user_bram_emu
    import qdr_emu_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12,
    parameter int RD_LATENCY    = 3,
    parameter int CALIB_CYCLES  = 64
) (
    input  logic                      qdr_clk,
    input  logic                      resetn,
    output logic                      init_calib_complete,
    input  logic                      user_app_wr_cmd,
    input  logic [QDR_ADDR_WIDTH-1:0] user_app_wr_addr,
    input  logic [W-1:0]              user_app_wr_data,
    input  logic                      user_app_rd_cmd,
    input  logic [QDR_ADDR_WIDTH-1:0] user_app_rd_addr,
    output logic [W-1:0]              user_app_rd_data,
    output logic                      user_app_rd_valid,
    output logic                      cmd_drop,
    output logic                      addr_alias
);

    localparam int CNT_W = MEM_ADDR_BITS + $clog2(CALIB_CYCLES + 1);
`ifdef QDR_EMU_ZERO_INIT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2**MEM_ADDR_BITS) - 1);
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALIB_CYCLES - 1);
`endif

    emu_state_e               state_r, state_nxt_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
    logic                     icc_r, drop_r, alias_r;
    logic                     wr_acc_s, rd_acc_s;
    logic                     ram_we_s;
    logic [MEM_ADDR_BITS-1:0] ram_waddr_s;
    logic [W-1:0]             ram_wdata_s;
    logic [W-1:0]             ram_q_s;
    logic                     vld_r [0:RD_LATENCY-1];
    logic [W-1:0]             dat_r [1:RD_LATENCY-1];
    logic                     rd_valid_r;
    logic [W-1:0]             rd_data_r;

    // Commands are only honoured once calibrated and outside reset.
    assign wr_acc_s = resetn && user_app_wr_cmd && (state_r == READY);
    assign rd_acc_s = resetn && user_app_rd_cmd && (state_r == READY);

    // Next-state and calibration counter: count to CNT_LAST, then stay in READY.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            CALIB: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = READY;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            READY: begin
                state_nxt_s = READY;
            end
            default: begin
                state_nxt_s = CALIB;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and calibration-done register.
    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            state_r <= CALIB;
            cnt_r   <= {CNT_W{1'b0}};
            icc_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            icc_r   <= (state_nxt_s == READY);
        end
    end

    // Sticky status flags: commands dropped during calibration, aliased addresses.
    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            drop_r  <= 1'b0;
            alias_r <= 1'b0;
        end else begin
            if ((state_r == CALIB) && (user_app_wr_cmd || user_app_rd_cmd)) begin
                drop_r <= 1'b1;
            end
            if ((wr_acc_s && upper_bits_set(user_app_wr_addr, MEM_ADDR_BITS)) ||
                (rd_acc_s && upper_bits_set(user_app_rd_addr, MEM_ADDR_BITS))) begin
                alias_r <= 1'b1;
            end
        end
    end

`ifdef QDR_EMU_ZERO_INIT_EN
    // RAM write mux: zero sweep during calibration, user writes afterwards.
    always_comb begin
        ram_we_s    = wr_acc_s;
        ram_waddr_s = user_app_wr_addr[MEM_ADDR_BITS-1:0];
        ram_wdata_s = user_app_wr_data;
        if (resetn && (state_r == CALIB)) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = cnt_r[MEM_ADDR_BITS-1:0];
            ram_wdata_s = {W{1'b0}};
        end else begin
            ram_we_s    = wr_acc_s;
        end
    end
`else
    // RAM write port driven directly by accepted user writes.
    always_comb begin
        ram_we_s    = wr_acc_s;
        ram_waddr_s = user_app_wr_addr[MEM_ADDR_BITS-1:0];
        ram_wdata_s = user_app_wr_data;
    end
`endif

    qdr_emu_sdp_ram #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_ram (
        .clk   (qdr_clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (rd_acc_s),
        .raddr (user_app_rd_addr[MEM_ADDR_BITS-1:0]),
        .rdata (ram_q_s)
    );

    // Valid delay line; stage 0 lines up with the RAM read register.
    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_r[i] <= 1'b0;
            end
        end else begin
            vld_r[0] <= rd_acc_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    // Data delay line; qualified by the valid line so it needs no reset.
    always_ff @(posedge qdr_clk) begin
        dat_r[1] <= ram_q_s;
        for (int i = 2; i < RD_LATENCY; i++) begin
            dat_r[i] <= dat_r[i-1];
        end
    end

    // Output register: pulse valid, hold data between responses.
    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {W{1'b0}};
        end else begin
            rd_valid_r <= vld_r[RD_LATENCY-1];
            if (vld_r[RD_LATENCY-1]) begin
                rd_data_r <= dat_r[RD_LATENCY-1];
            end
        end
    end

    assign init_calib_complete = icc_r;
    assign user_app_rd_valid   = rd_valid_r;
    assign user_app_rd_data    = rd_data_r;
    assign cmd_drop            = drop_r;
    assign addr_alias          = alias_r;

endmodule

// File: tb/tb_qdr_user_bram_emu.sv
// Self-checking bench for qdr_user_bram_emu: directed table, hand sequences,
// and randomized traffic against a behavioural memory/response model.
module tb_qdr_user_bram_emu;

`ifdef QDR_EMU_ZERO_INIT_EN
    localparam int CAL = 4096;
    localparam bit ZI  = 1'b1;
`else
    localparam int CAL = 64;
    localparam bit ZI  = 1'b0;
`endif
    localparam int LAT = 3;

    logic         qdr_clk = 1'b0;
    logic         resetn;
    logic         init_calib_complete;
    logic         wr_cmd, rd_cmd;
    logic [18:0]  wr_addr, rd_addr;
    logic [143:0] wr_data;
    logic [143:0] rd_data;
    logic         rd_valid, cmd_drop, addr_alias;

    qdr_user_bram_emu dut (
        .qdr_clk             (qdr_clk),
        .resetn              (resetn),
        .init_calib_complete (init_calib_complete),
        .user_app_wr_cmd     (wr_cmd),
        .user_app_wr_addr    (wr_addr),
        .user_app_wr_data    (wr_data),
        .user_app_rd_cmd     (rd_cmd),
        .user_app_rd_addr    (rd_addr),
        .user_app_rd_data    (rd_data),
        .user_app_rd_valid   (rd_valid),
        .cmd_drop            (cmd_drop),
        .addr_alias          (addr_alias)
    );

    always #5 qdr_clk = ~qdr_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        bit           kn;
        logic [143:0] data;
    } resp_t;

    resp_t        pend[$];
    logic [143:0] m_mem [0:4095];
    bit           m_kn  [0:4095];
    int           cyc = 0;
    int           rel = 0;
    bit           m_drop = 1'b0, m_alias = 1'b0, m_dk = 1'b1;
    logic [143:0] m_data = 144'd0;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_word(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance model, compare every output.
    task automatic step(input logic rst, input logic wr, input logic [18:0] wa,
                        input logic [143:0] wd, input logic rd, input logic [18:0] ra);
        resp_t r;
        bit    ev;
        resetn = rst; wr_cmd = wr; wr_addr = wa; wr_data = wd; rd_cmd = rd; rd_addr = ra;
        @(posedge qdr_clk);
        cyc++;
        if (!rst) begin
            pend.delete();
            m_drop = 1'b0; m_alias = 1'b0; m_data = 144'd0; m_dk = 1'b1; rel = 0;
            if (ZI) begin
                for (int i = 0; i < 4096; i++) begin
                    m_mem[i] = 144'd0;
                    m_kn[i]  = 1'b1;
                end
            end
        end else begin
            if (rel >= CAL) begin
                if (rd) begin
                    if (wr && (wa[11:0] == ra[11:0])) begin
                        r.data = wd; r.kn = 1'b1;
                    end else begin
                        r.data = m_mem[ra[11:0]]; r.kn = m_kn[ra[11:0]];
                    end
                    r.due = cyc + LAT;
                    pend.push_back(r);
                end
                if (wr) begin
                    m_mem[wa[11:0]] = wd;
                    m_kn[wa[11:0]]  = 1'b1;
                end
                if ((wr && wa[18:12] != 7'd0) || (rd && ra[18:12] != 7'd0)) m_alias = 1'b1;
            end else if (wr || rd) begin
                m_drop = 1'b1;
            end
            if (rel < CAL) rel++;
        end
        #1;
        ev = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            ev = 1'b1; m_data = r.data; m_dk = r.kn;
        end
        chk_bit("m_icc", init_calib_complete, rel >= CAL);
        chk_bit("m_rd_valid", rd_valid, ev);
        chk_bit("m_cmd_drop", cmd_drop, m_drop);
        chk_bit("m_addr_alias", addr_alias, m_alias);
        if (m_dk) chk_word("m_rd_data", rd_data, m_data);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 19'd0, 144'd0, 1'b0, 19'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic         wr;
        logic [18:0]  wa;
        logic [143:0] wd;
        logic         rd;
        logic [18:0]  ra;
        logic         ev;
        logic [143:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic [18:0] wa, input logic [143:0] wd,
                                input logic rd, input logic [18:0] ra,
                                input logic ev, input logic [143:0] ed);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    logic [143:0] pat_a5;
    logic [159:0] rnd;
    logic [18:0]  rwa, rra;

    initial begin
        pat_a5 = {18{8'hA5}};
        resetn = 1'b0; wr_cmd = 1'b0; rd_cmd = 1'b0;
        wr_addr = 19'd0; rd_addr = 19'd0; wr_data = 144'd0;

        // write 5, read 5, response exactly LAT cycles later
        tbl.push_back(mk(1'b1, 19'd5, pat_a5, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b1, 19'd5, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b1, pat_a5));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        // back-to-back writes then back-to-back reads, in-order gapless responses
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(1'b1, 19'(j), 144'(j), 1'b0, 19'd0, 1'b0, 144'd0));
        for (int j = 0; j < 12; j++)
            tbl.push_back(mk(1'b0, 19'd0, 144'd0, j < 8, 19'(j), (j >= 3 && j < 11), 144'(j - 3)));
        // same-cycle write/read bypass
        tbl.push_back(mk(1'b1, 19'h10, 144'h1, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b1, 19'h10, 144'hBEEF, 1'b1, 19'h10, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b1, 144'hBEEF));
        // write then read on the next cycle
        tbl.push_back(mk(1'b1, 19'h20, 144'h33, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b1, 19'h20, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b1, 144'h33));
        // aliased write, read through the low address
        tbl.push_back(mk(1'b1, 19'h40005, 144'h77, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b1, 19'h00005, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b0, 144'd0));
        tbl.push_back(mk(1'b0, 19'd0, 144'd0, 1'b0, 19'd0, 1'b1, 144'h77));

        // reset, then calibration timing with a dropped read at cycle 10
        step(1'b0, 1'b0, 19'd0, 144'd0, 1'b0, 19'd0);
        step(1'b0, 1'b0, 19'd0, 144'd0, 1'b0, 19'd0);
        chk_bit("reset_icc", init_calib_complete, 1'b0);
        chk_bit("reset_valid", rd_valid, 1'b0);
        chk_word("reset_data", rd_data, 144'd0);
        for (int e = 1; e <= CAL + 4; e++) begin
            step(1'b1, 1'b0, 19'd0, 144'd0, e == 10, 19'd3);
            chk_bit("calib_icc", init_calib_complete, e >= CAL);
            chk_bit("calib_no_valid", rd_valid, 1'b0);
        end
        chk_bit("calib_drop", cmd_drop, 1'b1);
        chk_bit("calib_no_alias", addr_alias, 1'b0);

        // directed table
        foreach (tbl[k]) begin
            step(1'b1, tbl[k].wr, tbl[k].wa, tbl[k].wd, tbl[k].rd, tbl[k].ra);
            chk_bit("tbl_valid", rd_valid, tbl[k].ev);
            if (tbl[k].ev) chk_word("tbl_data", rd_data, tbl[k].ed);
        end
        chk_bit("alias_set", addr_alias, 1'b1);

        // reset while a read is in flight; read sampled in the reset cycle too
        step(1'b1, 1'b1, 19'h30, 144'h5, 1'b0, 19'd0);
        step(1'b1, 1'b0, 19'd0, 144'd0, 1'b1, 19'h30);
        step(1'b0, 1'b0, 19'd0, 144'd0, 1'b1, 19'h30);
        chk_bit("rst_icc_clr", init_calib_complete, 1'b0);
        chk_bit("rst_alias_clr", addr_alias, 1'b0);
        chk_bit("rst_drop_clr", cmd_drop, 1'b0);
        for (int k = 1; k <= CAL; k++) begin
            idle();
            if (k <= 4) chk_bit("rst_no_valid", rd_valid, 1'b0);
        end
        chk_bit("recal_icc", init_calib_complete, 1'b1);
        step(1'b1, 1'b0, 19'd0, 144'd0, 1'b1, 19'h30);
        idle();
        idle();
        idle();
        chk_bit("post_rst_valid", rd_valid, 1'b1);
        chk_word("post_rst_data", rd_data, ZI ? 144'd0 : 144'h5);

        // randomized traffic, with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rwa = 19'($urandom_range(0, 15));
            rra = 19'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) rwa[18:12] = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 9) == 0) rra[18:12] = 7'($urandom_range(1, 127));
            step(i != 300, 1'($urandom_range(0, 1)), rwa, rnd[143:0],
                 1'($urandom_range(0, 1)), rra);
        end
        repeat (LAT + 1) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
